// File: rtl/ysyx_23060025_mem_arbiter.sv
// Two-master memory arbiter: IFU and LSU share one memory port.
// Only one transaction is outstanding at a time. When both masters request
// together, round-robin arbitration gives the grant to the master that was
// not granted last. Request and response handshakes are passed straight
// through to the granted master. Non-granted masters see zero valid/ready.
module ysyx_23060025_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_W-1:0]     ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_W-1:0]     lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_IFU = 3'd1,
        ST_REQ_LSU = 3'd2,
        ST_RSP_IFU = 3'd3,
        ST_RSP_LSU = 3'd4
    } state_t;

    state_t state_reg;
    logic   last_grant_reg;

    // LSU wins in IDLE when it is the only requester, or when both request
    // and the IFU held the previous grant.
    logic pick_lsu;
    assign pick_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant_reg == GRANT_IFU));

    // Transaction sequencer: IDLE -> REQ_x -> RSP_x -> IDLE, grant recorded on entry to REQ_x.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= GRANT_IFU;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_lsu) begin
                        state_reg      <= ST_REQ_LSU;
                        last_grant_reg <= GRANT_LSU;
                    end else if (ifu_req_valid) begin
                        state_reg      <= ST_REQ_IFU;
                        last_grant_reg <= GRANT_IFU;
                    end
                end
                ST_REQ_IFU: if (mem_req_ready) state_reg <= ST_RSP_IFU;
                ST_REQ_LSU: if (mem_req_ready) state_reg <= ST_RSP_LSU;
                ST_RSP_IFU: if (mem_rsp_valid && ifu_rsp_ready) state_reg <= ST_IDLE;
                ST_RSP_LSU: if (mem_rsp_valid && lsu_rsp_ready) state_reg <= ST_IDLE;
                default:    state_reg <= ST_IDLE;
            endcase
        end
    end

    // Phase selects decoded from the registered state.
    logic sel_req_ifu;
    logic sel_req_lsu;
    logic sel_rsp_ifu;
    logic sel_rsp_lsu;

    assign sel_req_ifu = (state_reg == ST_REQ_IFU);
    assign sel_req_lsu = (state_reg == ST_REQ_LSU);
    assign sel_rsp_ifu = (state_reg == ST_RSP_IFU);
    assign sel_rsp_lsu = (state_reg == ST_RSP_LSU);

    // Request channel: only the granted master sees mem_req_ready.
    assign mem_req_valid = sel_req_ifu | sel_req_lsu;
    assign ifu_req_ready = sel_req_ifu & mem_req_ready;
    assign lsu_req_ready = sel_req_lsu & mem_req_ready;

    // Address comes from the granted master; zero outside the request phase.
    assign mem_addr = ({ADDR_W{sel_req_ifu}} & ifu_addr)
                    | ({ADDR_W{sel_req_lsu}} & lsu_addr);

    // Instruction fetches are always reads, so only an LSU grant can write.
    assign mem_wen = sel_req_lsu & lsu_wen;

    // Store data and byte enables gated per byte lane; fetches drive zero.
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign mem_wstrb[gi]          = sel_req_lsu & lsu_wstrb[gi];
            assign mem_wdata[gi*8 +: 8]   = {8{sel_req_lsu}} & lsu_wdata[gi*8 +: 8];
        end
    endgenerate

    // Response channel: stray mem_rsp_valid outside RSP_x reaches nobody.
    assign ifu_rsp_valid = sel_rsp_ifu & mem_rsp_valid;
    assign lsu_rsp_valid = sel_rsp_lsu & mem_rsp_valid;
    assign mem_rsp_ready = (sel_rsp_ifu & ifu_rsp_ready)
                         | (sel_rsp_lsu & lsu_rsp_ready);

    // Read data is broadcast; the rsp_valid lines qualify it.
    assign ifu_rdata = mem_rdata;
    assign lsu_rdata = mem_rdata;

endmodule

// File: tb/tb_ysyx_23060025_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter. Expected grants and
// read data are queued when traffic is set up and consumed as the DUT
// completes memory handshakes; directed phases cover stalls, back-pressure
// and reset during a response.
module tb_ysyx_23060025_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_ready;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid;
    logic          lsu_req_ready;
    logic          lsu_wen;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic [SW-1:0] lsu_wstrb;
    logic          lsu_rsp_valid;
    logic          lsu_rsp_ready;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_rsp_valid;
    logic          mem_rsp_ready;
    logic [DW-1:0] mem_rdata;

    ysyx_23060025_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_wen       (lsu_wen),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_wstrb     (lsu_wstrb),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rdata     (mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic        lsu;
        logic [31:0] rdata;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_txn(input logic lsu, input logic [31:0] addr);
        req_t e;
        rsp_t r;
        e.lsu   = lsu;
        e.addr  = addr;
        r.lsu   = lsu;
        r.rdata = mem_fn(addr);
        req_q.push_back(e);
        rsp_q.push_back(r);
        $display("queued %s read addr=0x%08h", lsu ? "LSU" : "IFU", addr);
    endtask

    // Free-running traffic: masters keep requesting, memory always ready and
    // answers one cycle after each accepted request. Runs until the queues drain.
    task automatic run_auto(input logic ifu_on, input logic lsu_on, input int budget);
        logic        prev_req_hs = 1'b0;
        logic        prev_rsp_hs = 1'b0;
        logic [31:0] prev_addr   = '0;
        int          last_cyc    = -1;
        int          n           = 0;
        req_t        e;
        rsp_t        r;
        ifu_req_valid = ifu_on;
        lsu_req_valid = lsu_on;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wstrb     = '0;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        mem_req_ready = 1'b1;
        while (n < budget) begin
            if (prev_req_hs) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = mem_fn(prev_addr);
            end else if (prev_rsp_hs) begin
                mem_rsp_valid = 1'b0;
                mem_rdata     = '0;
            end
            #1;
            prev_req_hs = 1'b0;
            prev_rsp_hs = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                prev_req_hs = 1'b1;
                prev_addr   = mem_addr;
                if (req_q.size() == 0) begin
                    chk("extra_grant", 32'(1), 32'(0));
                end else begin
                    e = req_q.pop_front();
                    chk("grant_lsu", 32'(lsu_req_ready), 32'(e.lsu));
                    chk("grant_ifu", 32'(ifu_req_ready), 32'(!e.lsu));
                    chk("grant_addr", mem_addr, e.addr);
                    chk("grant_wen", 32'(mem_wen), 32'(0));
                    $display("grant %s addr=0x%08h cycle=%0d", e.lsu ? "LSU" : "IFU", e.addr, cyc);
                end
                if (last_cyc >= 0) chk("grant_period", cyc - last_cyc, 3);
                last_cyc = cyc;
            end
            if (mem_rsp_valid && mem_rsp_ready) begin
                prev_rsp_hs = 1'b1;
                if (rsp_q.size() == 0) begin
                    chk("extra_rsp", 32'(1), 32'(0));
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_lsu_valid", 32'(lsu_rsp_valid), 32'(r.lsu));
                    chk("rsp_ifu_valid", 32'(ifu_rsp_valid), 32'(!r.lsu));
                    chk("rsp_rdata", r.lsu ? lsu_rdata : ifu_rdata, r.rdata);
                    $display("response %s rdata=0x%08h", r.lsu ? "LSU" : "IFU", r.rdata);
                end
            end
            if (req_q.size() == 0 && rsp_q.size() == 0 && !prev_req_hs && !prev_rsp_hs) break;
            @(negedge clock);
            n++;
        end
        if (n >= budget) chk("auto_timeout", 32'(req_q.size() + rsp_q.size()), 32'(0));
        req_q.delete();
        rsp_q.delete();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        ifu_rsp_ready = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        lsu_wstrb     = '0;
        lsu_rsp_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state, with a stray memory response that must be ignored.
        mem_rsp_valid = 1'b1;
        #1;
        chk("rst_ifu_req_ready", 32'(ifu_req_ready), 32'(0));
        chk("rst_lsu_req_ready", 32'(lsu_req_ready), 32'(0));
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
        chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(0));
        chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(0));
        chk("rst_mem_rsp_ready", 32'(mem_rsp_ready), 32'(0));
        $display("reset state checked");
        @(negedge clock);
        mem_rsp_valid = 1'b0;

        // First simultaneous request after reset goes to the LSU.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0200;
        #1;
        chk("first_idle_mem_valid", 32'(mem_req_valid), 32'(0));
        @(negedge clock);
        #1;
        chk("first_mem_valid", 32'(mem_req_valid), 32'(1));
        chk("first_mem_addr", mem_addr, 32'h8000_0200);
        chk("first_lsu_ready_lo", 32'(lsu_req_ready), 32'(0));
        chk("first_ifu_ready", 32'(ifu_req_ready), 32'(0));
        mem_req_ready = 1'b1;
        #1;
        chk("first_lsu_ready_hi", 32'(lsu_req_ready), 32'(1));
        chk("first_ifu_ready_hi", 32'(ifu_req_ready), 32'(0));
        $display("first simultaneous request granted to LSU");
        reset         = 1'b1;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Both masters requesting continuously: grants alternate, 3 cycles apart.
        ifu_addr = 32'h8000_0000;
        lsu_addr = 32'h8000_1000;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_txn(1'b1, lsu_addr);
            else            push_txn(1'b0, ifu_addr);
        end
        run_auto(1'b1, 1'b1, 200);

        // IFU fetch stalled by memory; LSU request arriving mid-stall must wait.
        @(negedge clock);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b0;
        ifu_rsp_ready = 1'b0;
        lsu_rsp_ready = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                lsu_req_valid = 1'b1;
                lsu_addr      = 32'h8000_0010;
                lsu_wen       = 1'b1;
                lsu_wdata     = 32'hDEAD_BEEF;
                lsu_wstrb     = 4'h3;
            end
            #1;
            chk("stall_mem_valid", 32'(mem_req_valid), 32'(1));
            chk("stall_mem_addr", mem_addr, 32'h8000_0000);
            chk("stall_lsu_ready", 32'(lsu_req_ready), 32'(0));
            chk("stall_ifu_ready", 32'(ifu_req_ready), 32'(0));
            chk("stall_mem_wen", 32'(mem_wen), 32'(0));
            chk("stall_mem_wdata", mem_wdata, 32'(0));
            chk("stall_mem_wstrb", 32'(mem_wstrb), 32'(0));
            $display("stall cycle %0d mem_addr=0x%08h", i, mem_addr);
            @(negedge clock);
        end
        mem_req_ready = 1'b1;
        #1;
        chk("stall_ifu_accept", 32'(ifu_req_ready), 32'(1));
        chk("stall_lsu_blocked", 32'(lsu_req_ready), 32'(0));
        @(negedge clock);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFE_0001;
        ifu_rsp_ready = 1'b1;
        #1;
        chk("fetch_rsp_valid", 32'(ifu_rsp_valid), 32'(1));
        chk("fetch_rdata", ifu_rdata, 32'hCAFE_0001);
        chk("fetch_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(0));
        chk("fetch_mem_rsp_ready", 32'(mem_rsp_ready), 32'(1));
        $display("stalled fetch completed rdata=0x%08h", ifu_rdata);
        @(negedge clock);
        mem_rsp_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        #1;
        chk("bubble_mem_valid", 32'(mem_req_valid), 32'(0));

        // LSU store with response back-pressure.
        @(negedge clock);
        #1;
        chk("store_mem_valid", 32'(mem_req_valid), 32'(1));
        chk("store_mem_addr", mem_addr, 32'h8000_0010);
        chk("store_mem_wen", 32'(mem_wen), 32'(1));
        chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("store_mem_wstrb", 32'(mem_wstrb), 32'h3);
        chk("store_lsu_ready_lo", 32'(lsu_req_ready), 32'(0));
        mem_req_ready = 1'b1;
        #1;
        chk("store_lsu_ready_hi", 32'(lsu_req_ready), 32'(1));
        @(negedge clock);
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = '0;
        lsu_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_mem_rsp_ready", 32'(mem_rsp_ready), 32'(0));
            chk("bp_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(1));
            chk("bp_mem_req_valid", 32'(mem_req_valid), 32'(0));
            $display("store ack held cycle %0d", i);
            @(negedge clock);
        end
        lsu_rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(mem_rsp_ready), 32'(1));
        @(negedge clock);
        #1;
        chk("post_store_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(0));
        chk("post_store_mem_rsp_ready", 32'(mem_rsp_ready), 32'(0));
        mem_rsp_valid = 1'b0;
        lsu_rsp_ready = 1'b0;

        // Reset while a fetch response is pending.
        @(negedge clock);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0020;
        mem_req_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("abort_req_valid", 32'(mem_req_valid), 32'(1));
        @(negedge clock);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        ifu_rsp_ready = 1'b0;
        #1;
        chk("abort_rsp_valid_pre", 32'(ifu_rsp_valid), 32'(1));
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("abort_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(0));
        chk("abort_mem_rsp_ready", 32'(mem_rsp_ready), 32'(0));
        chk("abort_mem_req_valid", 32'(mem_req_valid), 32'(0));
        $display("reset during fetch response aborted transaction");
        reset         = 1'b0;
        mem_rsp_valid = 1'b0;

        // IFU-only request after the abort, then a fresh contended pair.
        ifu_addr = 32'h8000_0040;
        push_txn(1'b0, ifu_addr);
        run_auto(1'b1, 1'b0, 50);
        @(negedge clock);
        lsu_addr = 32'h8000_0300;
        push_txn(1'b1, lsu_addr);
        push_txn(1'b0, ifu_addr);
        run_auto(1'b1, 1'b1, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_mem_arbiter.md
YSYX_23060025_MEM_ARBITER -- requirements
Module: ysyx_23060025_mem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, default 32, address width of all ports.
REQ-002 Parameters SHALL include DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-003 Clock and reset SHALL be the only clock/reset inputs: one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_req_valid  in  1  instruction fetch request.
- ifu_req_ready  out  1  fetch request accepted.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch data valid.
- ifu_rsp_ready  in  1  IFU accepts data.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  load/store request.
- lsu_req_ready  out  1  load/store request accepted.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wstrb  in  DATA_W/8  store byte enables.
- lsu_rsp_valid  out  1  load data / store ack valid.
- lsu_rsp_ready  in  1  LSU accepts response.
- lsu_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_wen  out  1  forwarded write enable.
- mem_addr  out  ADDR_W  forwarded address.
- mem_wdata  out  DATA_W  forwarded store data.
- mem_wstrb  out  DATA_W/8  forwarded byte enables.
- mem_rsp_valid  in  1  memory response valid.
- mem_rsp_ready  out  1  arbiter accepts response.
- mem_rdata  in  DATA_W  memory read data.

Function
REQ-005 The FSM SHALL have states IDLE, REQ_IFU, REQ_LSU, RSP_IFU and RSP_LSU; exactly one memory transaction is outstanding at a time.
REQ-006 In IDLE, when any req_valid is high, the arbiter SHALL select a winner and enter REQ_<winner> on the next edge; mem_req_valid rises one cycle after the master's req_valid.
REQ-007 Arbitration SHALL be round-robin via a last_grant register: if both are valid, the master not granted last wins; if one is valid, it wins.
REQ-008 last_grant SHALL be updated on entry to REQ_x.
REQ-009 In REQ_x, the block SHALL drive mem_req_valid=1 with mem_addr/wen/wdata/wstrb taken from master x.
REQ-010 In REQ_x, x_req_ready SHALL equal mem_req_ready and the other master's req_ready SHALL be 0.
REQ-011 Master x SHALL hold its request fields stable while in REQ_x; the grant SHALL NOT change until mem_req_valid and mem_req_ready are both high.
REQ-012 For REQ_IFU, the block SHALL drive mem_wen=0, mem_wdata=0 and mem_wstrb=0.
REQ-013 A request handshake in REQ_x SHALL move the FSM to RSP_x on the next edge.
REQ-014 In RSP_x, x_rsp_valid SHALL equal mem_rsp_valid and mem_rsp_ready SHALL equal x_rsp_ready; the other master's rsp_valid SHALL be 0.
REQ-015 A response handshake in RSP_x SHALL return the FSM to IDLE; back-to-back transactions therefore incur a one-cycle IDLE bubble.
REQ-016 Outside REQ_x, the block SHALL drive mem_req_valid=0, all mem request fields to 0, and both req_ready=0.
REQ-017 Outside RSP_x, the block SHALL drive mem_rsp_ready=0 and both rsp_valid=0; a stray mem_rsp_valid SHALL be ignored.
REQ-018 ifu_rdata and lsu_rdata SHALL be continuous copies of mem_rdata.
REQ-019 Response back-pressure (x_rsp_ready=0) SHALL hold the FSM in RSP_x indefinitely; the block has no timeout.

Reset
REQ-020 Reset SHALL force IDLE and last_grant=IFU on the next edge, aborting any transaction mid-flight; all valid/ready outputs read 0 in the cycle after reset.
REQ-021 With last_grant=IFU after reset, the first simultaneous request SHALL be granted to the LSU.

Verification
REQ-022 After reset, assert ifu and lsu req_valid together -> cycle+1: REQ_LSU, mem_req_valid=1, mem_addr=lsu_addr, lsu_req_ready=mem_req_ready, ifu_req_ready=0.
REQ-023 With both masters continuously requesting, mem ready=1 and rsp in 1 cycle -> grants alternate LSU, IFU, LSU, IFU, with a 3-cycle period per transaction.
REQ-024 IFU read of 0x80000000, mem_req_ready low for 4 cycles, lsu_req_valid rising mid-wait -> mem_addr stays 0x80000000 and lsu_req_ready=0 throughout.
REQ-025 LSU store wdata=0xDEADBEEF, wstrb=0x3, lsu_rsp_ready=0 for 3 cycles after mem_rsp_valid -> mem_rsp_ready=0 for 3 cycles, FSM held in RSP_LSU, then IDLE after handshake.
REQ-026 Assert reset during RSP_IFU -> next cycle IDLE, ifu_rsp_valid=0, mem_rsp_ready=0; a following IFU-only request is granted normally.
